// File: rtl/dmem_responder.sv
// dmem_responder
//   Wait-state data memory for the pipeline's MEM-stage load/store port.
//   Every access completes a fixed LATENCY cycles after the cycle it is first
//   seen. Completion is a one-cycle ready pulse. Misaligned, out-of-range and
//   read+write requests complete normally but raise err together with ready.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      request-to-ready cycles (1..15)
//   BASE_ADDR    byte address of word 0 (multiple of 4)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   adr        byte address, held while stall=1
//   wdata      store data, held while stall=1
//   mem_read   load request, held while stall=1
//   mem_write  store request, held while stall=1
//   rdata      load data, valid in the ready cycle, held until the next load completes
//   ready      one-cycle completion pulse
//   err        one-cycle error pulse, only together with ready
//   stall      (mem_read | mem_write) & ~ready, combinational

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, wdata_q;
    logic        rd_q, wr_q;
    logic        err_q;
    logic        latch;
    logic        commit;

    logic [31:0] mem [DEPTH_WORDS];

    // The request being committed: straight from the ports when IDLE commits
    // on the accepting edge (LATENCY == 1), otherwise the latched copy.
    logic        in_idle;
    logic [31:0] cmd_adr, cmd_wdata, offset;
    logic        cmd_rd, cmd_wr;
    logic        misaligned, out_of_range, conflict, cmd_err;
    logic [AW-1:0] idx;

    assign in_idle   = (state_q == StIdle);
    assign cmd_adr   = in_idle ? adr       : adr_q;
    assign cmd_wdata = in_idle ? wdata     : wdata_q;
    assign cmd_rd    = in_idle ? mem_read  : rd_q;
    assign cmd_wr    = in_idle ? mem_write : wr_q;

    // BASE_ADDR is word aligned, so offset[1:0] equals adr[1:0]. Once
    // adr >= BASE_ADDR, any offset bit above the index field means the
    // address is past the last word.
    assign offset       = cmd_adr - BASE_ADDR;
    assign misaligned   = (offset[1:0] != 2'b00);
    assign out_of_range = (cmd_adr < BASE_ADDR) || ((offset >> (AW + 2)) != 32'd0);
    assign conflict     = cmd_rd & cmd_wr;
    assign cmd_err      = misaligned | out_of_range | conflict;
    assign idx          = offset[AW+1:2];

    assign ready = (state_q == StResp);
    assign err   = ready & err_q;
    assign stall = (mem_read | mem_write) & ~ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_read | mem_write) begin
                    latch = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                        commit  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                // The request still on the port is the one just completed.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata   <= 32'd0;
            err_q   <= 1'b0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                adr_q   <= adr;
                wdata_q <= wdata;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
            end
            if (commit) begin
                err_q <= cmd_err;
                if (cmd_err) begin
                    rdata <= 32'd0;
                end else if (cmd_rd) begin
                    rdata <= mem[idx];
                end
            end
        end
    end

    // Contents survive reset; a reset at the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && cmd_wr && !cmd_err) begin
            mem[idx] <= cmd_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_v     [2];
    logic [31:0] adr_v     [2];
    logic [31:0] wdata_v   [2];
    logic        rd_v      [2];
    logic        wr_v      [2];
    logic [31:0] rdata_w   [2];
    logic        ready_w   [2];
    logic        err_w     [2];
    logic        stall_w   [2];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut2 (
        .clk(clk), .rst(rst_v[0]), .adr(adr_v[0]), .wdata(wdata_v[0]),
        .mem_read(rd_v[0]), .mem_write(wr_v[0]), .rdata(rdata_w[0]),
        .ready(ready_w[0]), .err(err_w[0]), .stall(stall_w[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .adr(adr_v[1]), .wdata(wdata_v[1]),
        .mem_read(rd_v[1]), .mem_write(wr_v[1]), .rdata(rdata_w[1]),
        .ready(ready_w[1]), .err(err_w[1]), .stall(stall_w[1])
    );

    // Drive one access on instance s, starting just after a rising edge, and hold
    // it until ready. Returns latency in cycles, stall-high cycles, data/err in the
    // ready cycle, ready cycle number, rdata in the request cycle and whether rdata
    // held that value until the ready cycle.
    task automatic access(input int s, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int stalls, output logic [31:0] rdo,
                          output logic ero, output int rcyc, output logic [31:0] pre,
                          output logic held, output logic to);
        adr_v[s] = a; wdata_v[s] = d; rd_v[s] = rd; wr_v[s] = wr;
        lat = -1; stalls = 0; rdo = 32'd0; ero = 1'b0; rcyc = -1; pre = 32'd0;
        held = 1'b1; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) pre = rdata_w[s];
            if (stall_w[s]) stalls++;
            if (ready_w[s]) begin
                lat = i; rdo = rdata_w[s]; ero = err_w[s]; rcyc = cyc; to = 1'b0;
                break;
            end
            if (rdata_w[s] !== pre) held = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd_v[s] = 1'b0; wr_v[s] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            tests_run++;
            if ({ready_w[s], err_w[s], stall_w[s], rdata_w[s]} !== 35'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b err=%b stall=%b rdata=%h expected all 0",
                         s, ready_w[s], err_w[s], stall_w[s], rdata_w[s]);
            end
        end
    endtask

    task automatic test_store_load();
        int lat, st, rc; logic [31:0] rdo, pre; logic ero, held, to;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 2 || st != 2 || ero !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_store: got lat=%0d stalls=%0d err=%b to=%b expected 2 2 0 0",
                     lat, st, ero, to);
        end
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 2 || st != 2) begin
            tests_failed++;
            $display("FAIL t1_load_timing: got lat=%0d stalls=%0d expected 2 2", lat, st);
        end
        tests_run++;
        if (rdo !== 32'hDEADBEEF || ero !== 1'b0) begin
            tests_failed++;
            $display("FAIL t1_load_data: got %h err=%b expected deadbeef err=0", rdo, ero);
        end
    endtask

    task automatic test_back_to_back();
        int lat, st, rc1, rc2, c0; logic [31:0] d1, d2, pre, p1; logic ero, held, h1, to;
        access(0, 1'b0, 1'b1, 32'h0, 32'h11112222, lat, st, d1, ero, rc1, pre, held, to);
        access(0, 1'b0, 1'b1, 32'h4, 32'h33334444, lat, st, d1, ero, rc1, pre, held, to);
        c0 = cyc;
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, st, d1, ero, rc1, p1, h1, to);
        access(0, 1'b1, 1'b0, 32'h4, 32'h0, lat, st, d2, ero, rc2, pre, held, to);
        tests_run++;
        if (rc1 - c0 != 2 || rc2 - c0 != 5) begin
            tests_failed++;
            $display("FAIL t2_ready_cycles: got c+%0d c+%0d expected c+2 c+5", rc1 - c0, rc2 - c0);
        end
        tests_run++;
        if (d1 !== 32'h11112222 || d2 !== 32'h33334444) begin
            tests_failed++;
            $display("FAIL t2_data: got %h %h expected 11112222 33334444", d1, d2);
        end
        tests_run++;
        if (!held || pre !== 32'h11112222 || !h1) begin
            tests_failed++;
            $display("FAIL t2_rdata_hold: got held=%b/%b pre=%h expected 1/1 11112222",
                     h1, held, pre);
        end
    endtask

    task automatic test_bad_addr();
        int lat, st, rc; logic [31:0] rdo, pre; logic ero, held, to;
        access(0, 1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, lat, st, rdo, ero, rc, pre, held, to);
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 2 || ero !== 1'b1 || rdo !== 32'd0) begin
            tests_failed++;
            $display("FAIL t3_misaligned: got lat=%0d err=%b rdata=%h expected 2 1 0", lat, ero, rdo);
        end
        access(0, 1'b0, 1'b1, 32'h400, 32'h1, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 2 || ero !== 1'b1 || rdo !== 32'd0) begin
            tests_failed++;
            $display("FAIL t3_out_of_range: got lat=%0d err=%b rdata=%h expected 2 1 0",
                     lat, ero, rdo);
        end
        access(0, 1'b1, 1'b0, 32'h3FC, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (rdo !== 32'hCAFEF00D || ero !== 1'b0) begin
            tests_failed++;
            $display("FAIL t3_last_word: got %h err=%b expected cafef00d err=0", rdo, ero);
        end
        // An out-of-range store must not alias onto word 0 either.
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (rdo !== 32'h11112222) begin
            tests_failed++;
            $display("FAIL t3_word0: got %h expected 11112222", rdo);
        end
    endtask

    task automatic test_conflict();
        int lat, st, rc; logic [31:0] rdo, pre; logic ero, held, to;
        access(0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, lat, st, rdo, ero, rc, pre, held, to);
        access(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 2 || ero !== 1'b1 || rdo !== 32'd0) begin
            tests_failed++;
            $display("FAIL t4_conflict: got lat=%0d err=%b rdata=%h expected 2 1 0", lat, ero, rdo);
        end
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (rdo !== 32'h0BADF00D) begin
            tests_failed++;
            $display("FAIL t4_mem8: got %h expected 0badf00d", rdo);
        end
    endtask

    task automatic test_reset_mid_store();
        int lat, st, rc, pulses; logic [31:0] rdo, pre; logic ero, held, to;
        access(0, 1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, lat, st, rdo, ero, rc, pre, held, to);
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        pulses = 0;
        adr_v[0] = 32'h8; wdata_v[0] = 32'h55; wr_v[0] = 1'b1;
        @(negedge clk); if (ready_w[0]) pulses++;
        @(posedge clk); #1;
        rst_v[0] = 1'b1; wr_v[0] = 1'b0;
        @(negedge clk); if (ready_w[0]) pulses++;
        @(posedge clk); #1;
        rst_v[0] = 1'b0;
        @(negedge clk); if (ready_w[0]) pulses++;
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL t5_no_ready: got %0d pulses expected 0", pulses);
        end
        tests_run++;
        if (rdata_w[0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL t5_rdata_reset: got %h expected 0", rdata_w[0]);
        end
        @(posedge clk); #1;
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || rdo !== 32'hA5A5A5A5 || ero !== 1'b0) begin
            tests_failed++;
            $display("FAIL t5_old_value: got %h err=%b expected a5a5a5a5 err=0", rdo, ero);
        end
    endtask

    task automatic test_latency1();
        int lat, st, rc; logic [31:0] rdo, pre; logic ero, held, to;
        access(1, 1'b0, 1'b1, 32'h4, 32'h12345678, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 1 || st != 1 || ero !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_store: got lat=%0d stalls=%0d err=%b expected 1 1 0", lat, st, ero);
        end
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, lat, st, rdo, ero, rc, pre, held, to);
        tests_run++;
        if (to || lat != 1 || st != 1) begin
            tests_failed++;
            $display("FAIL t6_load_timing: got lat=%0d stalls=%0d expected 1 1", lat, st);
        end
        tests_run++;
        if (rdo !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL t6_load_data: got %h expected 12345678", rdo);
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_v[s] = 1'b1; adr_v[s] = 32'd0; wdata_v[s] = 32'd0;
            rd_v[s] = 1'b0; wr_v[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(posedge clk); #1;
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(posedge clk); #1;
        test_store_load();
        test_back_to_back();
        test_bad_addr();
        test_conflict();
        test_reset_mid_store();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
